// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared definitions.
// Prefix codes, event record and frame FSM states.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Key event stream handshake bundle.
// Producer drives the head event, consumer drives ready.
interface ps2_key_receiver_if;

    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       evt_valid;
    logic       evt_ready;

    modport master (
        output evt_code,
        output evt_ext,
        output evt_brk,
        output evt_valid,
        input  evt_ready
    );

    modport slave (
        input  evt_code,
        input  evt_ext,
        input  evt_brk,
        input  evt_valid,
        output evt_ready
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO of key events.
// Head reads as zero while empty.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  ps2_evt_t      din_i,
    input  logic          pop_i,
    output ps2_evt_t      dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    ps2_evt_t      mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          pop_ok;
    logic          push_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign level_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem[rd_q];

    // A full FIFO still takes a push when the head leaves the same cycle.
    always_comb begin
        pop_ok  = pop_i & ~empty_o;
        push_ok = push_i & (~full_o | pop_ok);
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= din_i;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frame decode, prefix merge,
// event FIFO with overflow and frame error reporting.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT     = 2000
) (
    input  logic                        clk,
    input  logic                        clrn,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic [7:0]                  evt_code,
    output logic                        evt_ext,
    output logic                        evt_brk,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    input  logic                        ovf_clr,
    output logic                        frame_err,
    output logic [7:0]                  err_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] ck_sync_q;
    logic [SYNC_STAGES-1:0] dt_sync_q;
    logic                   ck_prev_q;
    logic                   s_clk;
    logic                   s_dat;
    logic                   fall;

    ps2_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  ecnt_q, ecnt_d;
    logic        ovf_q, ovf_d;
    logic        byte_ok;
    logic        err;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    ps2_evt_t    evt_in;
    ps2_evt_t    head;

    ps2_key_receiver_if evt_if ();

    assign s_clk = ck_sync_q[SYNC_STAGES-1];
    assign s_dat = dt_sync_q[SYNC_STAGES-1];
    assign fall  = ck_prev_q & ~s_clk;

    // Synchronisers idle high so reset release never looks like an edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ck_sync_q <= '1;
            dt_sync_q <= '1;
            ck_prev_q <= 1'b1;
        end else begin
            ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dt_sync_q <= {dt_sync_q[SYNC_STAGES-2:0], ps2_data};
            ck_prev_q <= s_clk;
        end
    end

    // Frame FSM, watchdog and prefix decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tcnt_d  = tcnt_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        byte_ok = 1'b0;
        err     = 1'b0;
        push    = 1'b0;
        evt_in  = '{ext: ext_q, brk: brk_q, code: shift_q};

        unique case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (fall && !s_dat) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d = {s_dat, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = s_dat;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (s_dat && (^{shift_q, par_q})) byte_ok = 1'b1;
                    else err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (fall) begin
                tcnt_d = '0;
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                tcnt_d  = '0;
                state_d = IDLE;
                idx_d   = '0;
                err     = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end

        if (err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok) begin
            if (shift_q == PS2_EXT_PREFIX) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_BRK_PREFIX) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Status: error pulse, saturating error count, sticky overflow.
    always_comb begin
        ferr_d = err;
        ecnt_d = ecnt_q;
        if (err && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 1'b1;
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push && full && !pop) ovf_d = 1'b1;
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tcnt_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ecnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tcnt_q  <= tcnt_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            ferr_q  <= ferr_d;
            ecnt_q  <= ecnt_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (clrn),
        .push_i  (push),
        .din_i   (evt_in),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    assign evt_if.evt_code  = head.code;
    assign evt_if.evt_ext   = head.ext;
    assign evt_if.evt_brk   = head.brk;
    assign evt_if.evt_valid = ~empty;
    assign evt_if.evt_ready = evt_ready;

    assign pop       = evt_if.evt_valid & evt_if.evt_ready;
    assign evt_code  = evt_if.evt_code;
    assign evt_ext   = evt_if.evt_ext;
    assign evt_brk   = evt_if.evt_brk;
    assign evt_valid = evt_if.evt_valid;
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;
    assign err_cnt   = ecnt_q;

endmodule
